// File: rtl/display_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package display_scan_pkg;

  typedef enum logic [1:0] {
    S_OFF,
    S_GUARD,
    S_SHOW
  } scan_state_t;

  // Active-low hex patterns, bit 0 = segment a ... bit 6 = segment g; entry 15 is leftmost.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_scan_seg7_hex.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_hex (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  import display_scan_pkg::*;

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/display_scan.sv
// Multiplexed seven-segment scanner with guard blanking between digits and
// frame-aligned (tear-free) display updates.
module display_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 50000,
  parameter int GUARD  = 16
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iEn,
  input  logic                  iLoad,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic [DIGITS-1:0]     iBlank,
  input  logic [DIGITS-1:0]     iDp,
  output logic [6:0]            oSeg,
  output logic                  oDp,
  output logic [DIGITS-1:0]     oAn,
  output logic                  oAck
);
  import display_scan_pkg::*;

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = max_int(DIV, GUARD) - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  scan_state_t          state;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     cnt;
  logic [4*DIGITS-1:0]  disp;
  logic [4*DIGITS-1:0]  pend;
  logic                 pend_valid;

  logic [3:0]           nibble;
  logic [6:0]           hex_seg;
  logic [DIGITS-1:0]    an_cur;
  logic                 showing;
  logic                 boundary;
  logic                 apply_now;

  always_comb begin
    nibble    = disp[4*int'(idx) +: 4];
    an_cur    = ~(DIGITS'(1) << idx);
    showing   = (state == S_SHOW);
    boundary  = showing && (cnt == SHOW_LAST) && (idx == IDX_LAST);
    apply_now = (state == S_OFF) || !iEn || boundary;
  end

  seg7_hex u_seg7_hex (
    .hex (nibble),
    .seg (hex_seg)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= S_OFF;
      idx   <= '0;
      cnt   <= '0;
    end else if (!iEn) begin
      state <= S_OFF;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_OFF: begin
          state <= S_GUARD;
          cnt   <= '0;
        end
        S_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state <= S_SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt == SHOW_LAST) begin
            state <= S_GUARD;
            cnt   <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_OFF;
          idx   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Loads land directly when dark or at the frame boundary; otherwise they wait in pend.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      oAck       <= 1'b0;
    end else begin
      oAck <= 1'b0;
      if (apply_now) begin
        if (iLoad) begin
          disp       <= iData;
          pend_valid <= 1'b0;
          oAck       <= 1'b1;
        end else if (pend_valid) begin
          disp       <= pend;
          pend_valid <= 1'b0;
          oAck       <= 1'b1;
        end
      end else if (iLoad) begin
        pend       <= iData;
        pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oAn  <= '1;
      oSeg <= 7'h7F;
      oDp  <= 1'b1;
    end else begin
      oAn  <= showing ? an_cur : '1;
      oSeg <= (showing && !iBlank[idx]) ? hex_seg : 7'h7F;
      oDp  <= !(showing && iDp[idx]);
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: expected digit windows are queued by each
// scenario and checked by a monitor as each anode-low window closes.
module tb_display_scan;

  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int GUARD  = 1;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] len;
    logic       stable;
  } win_t;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iEn;
  logic        iLoad;
  logic [31:0] iData;
  logic [7:0]  iBlank;
  logic [7:0]  iDp;
  logic [6:0]  oSeg;
  logic        oDp;
  logic [7:0]  oAn;
  logic        oAck;

  int   checks = 0;
  int   errors = 0;
  win_t exp_q[$];
  bit   sb_active = 1'b0;

  int         cyc = 0;
  bit         in_win = 1'b0;
  bit         prev_win = 1'b0;
  bit         fe_seen = 1'b0;
  int         fe_cyc = 0;
  int         gap_len = 0;
  logic [7:0] cur_an;
  logic [6:0] cur_seg;
  logic       cur_dp;
  logic [7:0] run_len;
  logic       cur_stable;
  int         ack_count = 0;
  logic [7:0] ack_an;
  logic [7:0] ack_len;

  display_scan #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .GUARD  (GUARD)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iEn    (iEn),
    .iLoad  (iLoad),
    .iData  (iData),
    .iBlank (iBlank),
    .iDp    (iDp),
    .oSeg   (oSeg),
    .oDp    (oDp),
    .oAn    (oAn),
    .oAck   (oAck)
  );

  always #5 iClk = ~iClk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Window monitor: samples 1 time unit after each rising edge.
  always begin
    @(posedge iClk);
    #1;
    cyc++;
    if (!iRst_n || !sb_active) begin
      in_win   = 1'b0;
      prev_win = 1'b0;
      fe_seen  = 1'b0;
      gap_len  = 0;
    end else if (oAn !== 8'hFF) begin
      if (!in_win) begin
        if (prev_win) begin
          checks++;
          if (gap_len != 1) begin
            errors++;
            $display("FAIL gap_len: got %0d blank cycles, want 1", gap_len);
          end
        end
        if (oAn === 8'hFE) begin
          if (fe_seen) begin
            checks++;
            if (cyc - fe_cyc != 40) begin
              errors++;
              $display("FAIL frame_period: got %0d cycles, want 40", cyc - fe_cyc);
            end
          end
          fe_seen = 1'b1;
          fe_cyc  = cyc;
        end
        in_win     = 1'b1;
        cur_an     = oAn;
        cur_seg    = oSeg;
        cur_dp     = oDp;
        run_len    = 8'd1;
        cur_stable = 1'b1;
      end else begin
        if (oAn !== cur_an || oSeg !== cur_seg || oDp !== cur_dp) cur_stable = 1'b0;
        run_len = run_len + 8'd1;
      end
    end else begin
      if (in_win) begin
        win_t obs;
        win_t e;
        in_win   = 1'b0;
        prev_win = 1'b1;
        gap_len  = 0;
        obs = {cur_an, cur_seg, cur_dp, run_len, cur_stable};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got an=%h seg=%h dp=%b len=%0d, want none", cur_an, cur_seg, cur_dp, run_len);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL window: got an=%h seg=%h dp=%b len=%0d stable=%b, want an=%h seg=%h dp=%b len=%0d stable=%b",
                     obs.an, obs.seg, obs.dp, obs.len, obs.stable, e.an, e.seg, e.dp, e.len, e.stable);
          end
        end
      end
      gap_len++;
    end
    if (iRst_n === 1'b1 && oAck === 1'b1) begin
      ack_count++;
      ack_an  = oAn;
      ack_len = in_win ? run_len : 8'd0;
    end
  end

  task automatic push_digits(input logic [31:0] data, input logic [7:0] blank, input logic [7:0] dp,
                             input int first, input int last);
    for (int k = first; k <= last; k++) begin
      win_t w;
      w.an     = ~(8'h01 << k);
      w.seg    = blank[k] ? 7'h7F : hex7(data[4*k +: 4]);
      w.dp     = ~dp[k];
      w.len    = 8'd4;
      w.stable = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_level(input int level, input int budget, output bit ok);
    int n = 0;
    while (exp_q.size() > level && n < budget) begin
      @(negedge iClk);
      n++;
    end
    ok = (exp_q.size() <= level);
  endtask

  task automatic wait_an(input logic [7:0] v, input int budget, output bit ok);
    int n = 0;
    while (oAn !== v && n < budget) begin
      @(negedge iClk);
      n++;
    end
    ok = (oAn === v);
  endtask

  task automatic do_reset;
    sb_active = 1'b0;
    exp_q.delete();
    @(negedge iClk);
    iRst_n = 1'b0;
    iEn    = 1'b0;
    iLoad  = 1'b0;
    iData  = '0;
    iBlank = '0;
    iDp    = '0;
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);
  endtask

  task automatic load_off(input logic [31:0] data);
    @(negedge iClk);
    iLoad = 1'b1;
    iData = data;
    @(negedge iClk);
    iLoad = 1'b0;
    iData = '0;
    @(negedge iClk);
  endtask

  task automatic pulse_load(input logic [31:0] data);
    @(negedge iClk);
    iLoad = 1'b1;
    iData = data;
    @(negedge iClk);
    iLoad = 1'b0;
    iData = '0;
  endtask

  task automatic test_reset;
    iRst_n = 1'b0;
    iEn    = 1'b0;
    iLoad  = 1'b0;
    iData  = '0;
    iBlank = '0;
    iDp    = '0;
    repeat (2) @(negedge iClk);
    checks++;
    if (oAn !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h, want ff", oAn); end
    checks++;
    if (oSeg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h, want 7f", oSeg); end
    checks++;
    if (oDp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b, want 1", oDp); end
    checks++;
    if (oAck !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b, want 0", oAck); end
    iRst_n = 1'b1;
    repeat (4) @(negedge iClk);
    checks++;
    if (oAn !== 8'hFF) begin errors++; $display("FAIL off_idle_an: got %h, want ff", oAn); end
  endtask

  task automatic test_scan_order;
    bit ok;
    do_reset;
    iLoad = 1'b1;
    iData = 32'h76543210;
    @(posedge iClk);
    #1;
    checks++;
    if (oAck !== 1'b1) begin errors++; $display("FAIL off_load_ack: got %b, want 1", oAck); end
    @(negedge iClk);
    iLoad = 1'b0;
    iData = '0;
    @(posedge iClk);
    #1;
    checks++;
    if (oAck !== 1'b0) begin errors++; $display("FAIL off_ack_width: got %b, want 0", oAck); end
    @(negedge iClk);
    push_digits(32'h76543210, 8'h00, 8'h00, 0, 7);
    push_digits(32'h76543210, 8'h00, 8'h00, 0, 7);
    sb_active = 1'b1;
    iEn = 1'b1;
    wait_level(0, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL scan_drain: got %0d pending windows, want 0", exp_q.size()); end
    sb_active = 1'b0;
    iEn = 1'b0;
  endtask

  task automatic test_tear_free;
    bit ok;
    int a0;
    do_reset;
    load_off(32'h11111111);
    a0 = ack_count;
    push_digits(32'h11111111, 8'h00, 8'h00, 0, 7);
    push_digits(32'h11111111, 8'h00, 8'h00, 0, 7);
    push_digits(32'h22222222, 8'h00, 8'h00, 0, 7);
    sb_active = 1'b1;
    iEn = 1'b1;
    wait_level(16, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tear_first_frame: got %0d pending windows, want 16", exp_q.size()); end
    wait_an(8'hF7, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tear_digit3: got an=%h, want f7", oAn); end
    pulse_load(32'h22222222);
    wait_level(0, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tear_drain: got %0d pending windows, want 0", exp_q.size()); end
    checks++;
    if (ack_count - a0 != 1) begin errors++; $display("FAIL tear_ack_count: got %0d, want 1", ack_count - a0); end
    checks++;
    if (ack_an !== 8'h7F || ack_len !== 8'd4) begin
      errors++;
      $display("FAIL tear_ack_time: got an=%h len=%0d, want an=7f len=4", ack_an, ack_len);
    end
    sb_active = 1'b0;
    iEn = 1'b0;
  endtask

  task automatic test_double_load;
    bit ok;
    int a0;
    do_reset;
    a0 = ack_count;
    push_digits(32'h00000000, 8'h00, 8'h00, 0, 7);
    push_digits(32'hFEDCBA98, 8'h00, 8'h00, 0, 7);
    push_digits(32'hFEDCBA98, 8'h00, 8'h00, 0, 7);
    sb_active = 1'b1;
    iEn = 1'b1;
    wait_an(8'hFD, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dbl_digit1: got an=%h, want fd", oAn); end
    pulse_load(32'h89ABCDEF);
    wait_an(8'hEF, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dbl_digit4: got an=%h, want ef", oAn); end
    pulse_load(32'hFEDCBA98);
    wait_level(0, 250, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dbl_drain: got %0d pending windows, want 0", exp_q.size()); end
    checks++;
    if (ack_count - a0 != 1) begin errors++; $display("FAIL dbl_ack_count: got %0d, want 1", ack_count - a0); end
    checks++;
    if (ack_an !== 8'h7F) begin errors++; $display("FAIL dbl_ack_time: got an=%h, want 7f", ack_an); end
    sb_active = 1'b0;
    iEn = 1'b0;
  endtask

  task automatic test_blank_dp;
    bit ok;
    do_reset;
    load_off(32'h76543210);
    iBlank = 8'h80;
    iDp    = 8'h01;
    push_digits(32'h76543210, 8'h80, 8'h01, 0, 7);
    sb_active = 1'b1;
    iEn = 1'b1;
    wait_level(0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL blank_drain: got %0d pending windows, want 0", exp_q.size()); end
    sb_active = 1'b0;
    iEn    = 1'b0;
    iBlank = '0;
    iDp    = '0;
  endtask

  task automatic test_disable;
    bit ok;
    int a0;
    do_reset;
    load_off(32'h01234567);
    push_digits(32'h01234567, 8'h00, 8'h00, 0, 4);
    sb_active = 1'b1;
    iEn = 1'b1;
    wait_level(0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dis_drain0: got %0d pending windows, want 0", exp_q.size()); end
    wait_an(8'hDF, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dis_digit5: got an=%h, want df", oAn); end
    a0 = ack_count;
    pulse_load(32'hCAFEBABE);
    sb_active = 1'b0;
    iEn = 1'b0;
    repeat (2) @(negedge iClk);
    checks++;
    if (oAn !== 8'hFF) begin errors++; $display("FAIL dis_an: got %h, want ff", oAn); end
    checks++;
    if (oSeg !== 7'h7F || oDp !== 1'b1) begin errors++; $display("FAIL dis_seg_dp: got seg=%h dp=%b, want 7f 1", oSeg, oDp); end
    repeat (2) @(negedge iClk);
    checks++;
    if (ack_count - a0 != 1) begin errors++; $display("FAIL dis_pend_ack: got %0d, want 1", ack_count - a0); end
    push_digits(32'hCAFEBABE, 8'h00, 8'h00, 0, 7);
    sb_active = 1'b1;
    iEn = 1'b1;
    wait_level(0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dis_restart: got %0d pending windows, want 0", exp_q.size()); end
    sb_active = 1'b0;
    iEn = 1'b0;
  endtask

  task automatic test_reset_pending;
    bit ok;
    int a0;
    do_reset;
    iEn = 1'b1;
    wait_an(8'hFB, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rp_digit2: got an=%h, want fb", oAn); end
    a0 = ack_count;
    pulse_load(32'h55555555);
    #2;
    iRst_n = 1'b0;
    #1;
    checks++;
    if (oAn !== 8'hFF || oSeg !== 7'h7F || oDp !== 1'b1 || oAck !== 1'b0) begin
      errors++;
      $display("FAIL rp_async_out: got an=%h seg=%h dp=%b ack=%b, want ff 7f 1 0", oAn, oSeg, oDp, oAck);
    end
    repeat (3) @(negedge iClk);
    push_digits(32'h00000000, 8'h00, 8'h00, 0, 7);
    sb_active = 1'b1;
    iRst_n = 1'b1;
    @(negedge iClk);
    checks++;
    if (oAn !== 8'hFF) begin errors++; $display("FAIL rp_first_guard_a: got %h, want ff", oAn); end
    @(negedge iClk);
    checks++;
    if (oAn !== 8'hFF) begin errors++; $display("FAIL rp_first_guard_b: got %h, want ff", oAn); end
    @(negedge iClk);
    checks++;
    if (oAn !== 8'hFE) begin errors++; $display("FAIL rp_first_show: got %h, want fe", oAn); end
    wait_level(0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rp_drain: got %0d pending windows, want 0", exp_q.size()); end
    checks++;
    if (ack_count != a0) begin errors++; $display("FAIL rp_no_ack: got %0d acks, want 0", ack_count - a0); end
    sb_active = 1'b0;
    iEn = 1'b0;
  endtask

  initial begin
    test_reset;
    test_scan_order;
    test_tear_free;
    test_double_load;
    test_blank_dp;
    test_disable;
    test_reset_pending;
    repeat (2) @(negedge iClk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The block SHALL have parameter DIGITS, default 8, giving the number of multiplexed digit positions.
REQ-002 The block SHALL have parameter DIV, default 50000, giving the SHOW-phase length per digit in clock cycles (legal range 1 or more).
REQ-003 The block SHALL have parameter GUARD, default 16, giving the anti-ghost blanking length before each digit in clock cycles (legal range 1 or more).
REQ-004 Port iClk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 Port iRst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port iEn, input, 1: scan enable; 0 turns the display off.
REQ-007 Port iLoad, input, 1: one-cycle request to update the displayed value.
REQ-008 Port iData, input, 4*DIGITS: hex nibbles; nibble k drives digit k, and nibble 0 is the rightmost digit.
REQ-009 Port iBlank, input, DIGITS: bit k=1 blanks digit k; sampled live.
REQ-010 Port iDp, input, DIGITS: bit k=1 lights the decimal point of digit k; sampled live.
REQ-011 Port oSeg, output, 7: active-low segments, where bit 0 is segment a and bit 6 is segment g.
REQ-012 Port oDp, output, 1: active-low decimal point.
REQ-013 Port oAn, output, DIGITS: active-low digit anodes, with at most one bit low at any time.
REQ-014 Port oAck, output, 1: one-cycle pulse confirming a load has been applied.

Function
REQ-015 FSM states SHALL be OFF (all anodes high), GUARD (all anodes high, digit index held) and SHOW (anode of the current digit low).
REQ-016 Transitions SHALL be as follows:
- OFF to GUARD when iEn=1.
- GUARD to SHOW after GUARD cycles.
- SHOW to GUARD after DIV cycles, with the digit index incremented modulo DIGITS.
- Any state to OFF in the cycle after iEn=0, with the digit index cleared to 0.
REQ-017 All outputs SHALL be registered, so oAn/oSeg/oDp change one cycle after the state change that causes them.
REQ-018 In SHOW, oSeg SHALL be the standard hex 0-F active-low pattern of the current nibble (for example, 0 gives 7'b1000000 and F gives 7'b0001110).
REQ-019 oSeg SHALL be 7'h7F if iBlank is set for the current digit or the state is not SHOW.
REQ-020 oDp SHALL be low only in SHOW with the iDp bit of the current digit set.
REQ-021 The display register SHALL change only at a frame boundary, defined as the last SHOW cycle of digit DIGITS-1, so that no frame shows mixed values.
REQ-022 iLoad=1 SHALL capture iData into a pending register and set a pending flag.
REQ-023 A further iLoad before the boundary SHALL overwrite the pending register (last wins), with one oAck only.
REQ-024 At the boundary, when pending is set, the display register SHALL take the pending value, pending SHALL clear, and oAck SHALL pulse in the next cycle.
REQ-025 When iLoad coincides with the boundary, the iData of that cycle SHALL be applied directly and oAck SHALL pulse next cycle.
REQ-026 In OFF, iLoad SHALL update the display register immediately, with oAck in the next cycle.
REQ-027 When iEn drops while a load is pending, the pending value SHALL be applied on entry to OFF and oAck SHALL pulse.
REQ-028 The phase counter SHALL be wide enough for max(DIV,GUARD)-1, SHALL reset to 0 on every state change, and SHALL never wrap within a phase.

Reset
REQ-029 While iRst_n=0, the block SHALL be in state OFF with digit index 0, counter 0, display and pending registers 0, and pending flag 0.
REQ-030 While iRst_n=0, outputs SHALL be oAn all ones, oSeg 7'h7F, oDp 1 and oAck 0.
REQ-031 A reset mid-frame or mid-load SHALL discard the pending load without an oAck.
REQ-032 After reset release, the first GUARD SHALL start in the first cycle iEn=1 is sampled.

Structure
REQ-033 A shared package SHALL hold the state enum (OFF/GUARD/SHOW) and the 16-entry active-low hex segment constant table.
REQ-034 Hex-to-segment decoding SHALL be a combinational sub-module seg7_hex (4-bit in, 7-bit active-low out), instantiated once and shared across all digits by the scan index.
REQ-035 The FSM, counters, load handshake and output registers SHALL reside in display_scan.

Verification
REQ-036 The bench SHALL use DIV=4, GUARD=1, DIGITS=8 for all scenarios.
REQ-037 Scan order: iEn=1, iData=32'h76543210, and all other inputs 0 SHALL produce:
- each of oAn = FE, FD, ... 7F low for exactly 4 cycles;
- a 1-cycle all-high gap between digits;
- the oSeg sequence 40, 79, 24, 30, 19, 12, 02, 78;
- a frame period of 40 cycles.
REQ-038 Tear-free load: after one frame of 32'h11111111, iLoad with 32'h22222222 mid-digit-3 SHALL leave digits 4-7 showing 1 (oSeg 79), change to 2 (oSeg 24) only in the next frame, and pulse oAck exactly once at the boundary+1.
REQ-039 Double load: iLoad with A then B within one frame SHALL display B next frame with a single oAck.
REQ-040 Blank and decimal point: iBlank=8'h80 and iDp=8'h01 SHALL give oSeg 7F on digit 7 (anode still low) and oDp 0 only on digit 0.
REQ-041 Disable and reset: iEn=0 mid-digit-5 SHALL drive oAn FF next cycle and restart at digit 0 on re-enable; iRst_n=0 with a load pending SHALL give outputs FF/7F/1/0 immediately and produce no oAck.
